// File: rtl/controle_formacao_pkg.sv
// Shared constants and state encoding for the enemy formation logic.
package pacote_inimigos;

  localparam int unsigned LARGURA_TELA = 640;
  localparam int unsigned ALTURA_TELA  = 480;

  localparam int unsigned ESPACO_PADRAO  = 40;
  localparam int unsigned LARGURA_PADRAO = 30;
  localparam int unsigned PASSO_X_PADRAO = 20;
  localparam int unsigned PASSO_Y_PADRAO = 20;

  typedef enum logic [1:0] {
    OCIOSO,
    MARCHA,
    LIMPA,
    INVADIU
  } estado_t;

endpackage

// File: rtl/controle_formacao_if.sv
// Kill request channel from collision logic into the formation scheduler.
interface controle_formacao_if #(
  parameter int unsigned IW = 5
) ();

  logic          abate_valido;
  logic [IW-1:0] abate_idx;
  logic          abate_pronto;

  modport master (output abate_valido, output abate_idx, input abate_pronto);
  modport slave  (input abate_valido, input abate_idx, output abate_pronto);

endinterface

// File: rtl/controle_formacao_bordas.sv
// Combinational bounds of the alive mask: extreme occupied columns and lowest occupied row.
module localizador_bordas #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 4,
  parameter int unsigned CW   = 3,
  parameter int unsigned RW   = 2
) (
  input  logic [COLS*ROWS-1:0] mask,
  output logic [CW-1:0]        cmin,
  output logic [CW-1:0]        cmax,
  output logic [RW-1:0]        rmax,
  output logic                 algum
);

  logic [COLS-1:0] col_viva;
  logic [ROWS-1:0] lin_viva;

  always_comb begin
    col_viva = '0;
    lin_viva = '0;
    cmin     = '0;
    cmax     = '0;
    rmax     = '0;
    algum    = |mask;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (mask[r*COLS+c]) begin
          col_viva[c] = 1'b1;
          lin_viva[r] = 1'b1;
        end
      end
    end
    // Ascending scans: last hit wins, so cmin scans columns in reverse order.
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_viva[c])          cmax = CW'(c);
      if (col_viva[COLS-1-c])   cmin = CW'(COLS - 1 - c);
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (lin_viva[r]) rmax = RW'(r);
    end
  end

endmodule

// File: rtl/controle_formacao.sv
// Enemy formation scheduler: alive mask, paced march with edge drops, kill handshake.
module controle_formacao
  import pacote_inimigos::*;
#(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned ESPACO       = ESPACO_PADRAO,
  parameter int unsigned LARGURA      = LARGURA_PADRAO,
  parameter int unsigned PASSO_X      = PASSO_X_PADRAO,
  parameter int unsigned PASSO_Y      = PASSO_Y_PADRAO,
  parameter int unsigned X0           = 20,
  parameter int unsigned Y0           = 40,
  parameter int unsigned Y_LIMITE     = 420,
  parameter int unsigned PERIODO_BASE = 25000000,
  parameter int unsigned PERIODO_MIN  = 2500000,
  parameter int unsigned DECREMENTO   = 700000
) (
  input  logic                          CLOCK_50,
  input  logic                          resetInimigo,
  input  logic                          pausa,
  input  logic                          iniciar_onda,
  controle_formacao_if.slave            abate,
  output logic [COLS*ROWS-1:0]          vivos,
  output logic [$clog2(COLS*ROWS):0]    n_vivos,
  output logic [9:0]                    x_form,
  output logic [9:0]                    y_form,
  output logic                          sentido,
  output logic                          passo,
  output logic                          onda_limpa,
  output logic                          invasao
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IW:0] TOTAL = (IW + 1)'(N);
  localparam logic [IW:0] UM    = (IW + 1)'(1);

  estado_t       estado;
  logic [31:0]   timer;
  logic [CW-1:0] cmin, cmax;
  logic [RW-1:0] rmax;
  logic          algum;
  logic [63:0]   reducao;
  logic [31:0]   periodo;
  logic [10:0]   borda_esq, borda_dir, fundo_desce;
  logic          desce, disparo, transfere, acerto;

  localizador_bordas #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_bordas (
    .mask  (vivos),
    .cmin  (cmin),
    .cmax  (cmax),
    .rmax  (rmax),
    .algum (algum)
  );

  always_comb begin
    // Widened product so large kill counts saturate to the floor instead of wrapping.
    reducao = 64'(32'(N) - 32'(n_vivos)) * 64'(DECREMENTO);
    if (reducao + 64'(PERIODO_MIN) >= 64'(PERIODO_BASE))
      periodo = 32'(PERIODO_MIN);
    else
      periodo = 32'(64'(PERIODO_BASE) - reducao);

    borda_esq   = 11'(x_form) + 11'(cmin) * 11'(ESPACO);
    borda_dir   = 11'(x_form) + 11'(cmax) * 11'(ESPACO) + 11'(LARGURA);
    fundo_desce = 11'(y_form) + 11'(PASSO_Y) + 11'(rmax) * 11'(ESPACO) + 11'(LARGURA);
    desce       = sentido ? (11'(borda_dir + 11'(PASSO_X)) > 11'(LARGURA_TELA))
                          : (borda_esq < 11'(PASSO_X));

    disparo   = (estado == MARCHA) && !pausa && algum && (timer >= periodo - 32'd1);
    transfere = abate.abate_valido && abate.abate_pronto;
    acerto    = transfere && (32'(abate.abate_idx) < N) && vivos[abate.abate_idx];
  end

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      estado             <= OCIOSO;
      vivos              <= '0;
      n_vivos            <= '0;
      x_form             <= 10'(X0);
      y_form             <= 10'(Y0);
      sentido            <= 1'b1;
      passo              <= 1'b0;
      abate.abate_pronto <= 1'b0;
      onda_limpa         <= 1'b0;
      invasao            <= 1'b0;
      timer              <= '0;
    end else begin
      passo <= 1'b0;
      if (iniciar_onda) begin
        estado             <= MARCHA;
        vivos              <= '1;
        n_vivos            <= TOTAL;
        x_form             <= 10'(X0);
        y_form             <= 10'(Y0);
        sentido            <= 1'b1;
        timer              <= '0;
        abate.abate_pronto <= 1'b1;
        onda_limpa         <= 1'b0;
        invasao            <= 1'b0;
      end else if (estado == MARCHA) begin
        if (!pausa) timer <= disparo ? '0 : timer + 32'd1;
        if (disparo) begin
          passo <= 1'b1;
          if (desce) begin
            y_form  <= y_form + 10'(PASSO_Y);
            sentido <= ~sentido;
          end else if (sentido) begin
            x_form <= x_form + 10'(PASSO_X);
          end else begin
            x_form <= x_form - 10'(PASSO_X);
          end
        end
        if (acerto) begin
          vivos[abate.abate_idx] <= 1'b0;
          n_vivos                <= n_vivos - UM;
        end
        // A wave cleared on the same edge as a fatal drop counts as cleared.
        if (acerto && n_vivos == UM) begin
          estado             <= LIMPA;
          onda_limpa         <= 1'b1;
          abate.abate_pronto <= 1'b0;
        end else if (disparo && desce && fundo_desce >= 11'(Y_LIMITE)) begin
          estado             <= INVADIU;
          invasao            <= 1'b1;
          abate.abate_pronto <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_controle_formacao.sv
// Directed plus randomized checks of the formation scheduler against a behavioural model.
module tb_controle_formacao;

  localparam int NC = 4, NR = 2, N = 8;
  localparam int ESP = 40, LARG = 30, PX = 20, PY = 20;
  localparam int XI = 20, YI = 40, YL = 200;
  localparam int BASE = 10, PMIN = 4, DEC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pau = 1'b0;
  logic       ini = 1'b0;
  logic       av  = 1'b0;
  logic [2:0] aidx = '0;
  logic [7:0] vivos;
  logic [3:0] n_vivos;
  logic [9:0] x_form, y_form;
  logic       sentido, passo, limpa, inv;

  controle_formacao_if #(.IW(3)) bus ();
  assign bus.abate_valido = av;
  assign bus.abate_idx    = aidx;

  controle_formacao #(
    .COLS(NC), .ROWS(NR), .ESPACO(ESP), .LARGURA(LARG), .PASSO_X(PX), .PASSO_Y(PY),
    .X0(XI), .Y0(YI), .Y_LIMITE(YL), .PERIODO_BASE(BASE), .PERIODO_MIN(PMIN), .DECREMENTO(DEC)
  ) dut (
    .CLOCK_50(clk), .resetInimigo(rst), .pausa(pau), .iniciar_onda(ini), .abate(bus),
    .vivos(vivos), .n_vivos(n_vivos), .x_form(x_form), .y_form(y_form), .sentido(sentido),
    .passo(passo), .onda_limpa(limpa), .invasao(inv)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0, passos = 0;

  // Model: 0 idle, 1 marching, 2 cleared, 3 invaded
  bit m_alive[N];
  int m_x, m_y, m_dir, m_timer, m_st;
  bit m_passo, m_limpa, m_inv, m_pronto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int conta();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_alive[i];
    return c;
  endfunction

  function automatic logic [7:0] mascara();
    logic [7:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = m_alive[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 0;
    m_x = XI; m_y = YI; m_dir = 1; m_timer = 0; m_st = 0;
    m_passo = 0; m_limpa = 0; m_inv = 0; m_pronto = 0;
  endtask

  task automatic model_step();
    int p, cmin, cmax, rmax, le, re, be;
    bit kill, inv_cond;
    if (rst) begin
      model_reset();
    end else if (ini) begin
      for (int i = 0; i < N; i++) m_alive[i] = 1;
      m_x = XI; m_y = YI; m_dir = 1; m_timer = 0; m_st = 1;
      m_passo = 0; m_limpa = 0; m_inv = 0; m_pronto = 1;
    end else begin
      m_passo = 0;
      if (m_st == 1) begin
        p = BASE - (N - conta()) * DEC;
        if (p < PMIN) p = PMIN;
        cmin = NC; cmax = -1; rmax = -1;
        for (int i = 0; i < N; i++)
          if (m_alive[i]) begin
            if (i % NC < cmin) cmin = i % NC;
            if (i % NC > cmax) cmax = i % NC;
            if (i / NC > rmax) rmax = i / NC;
          end
        kill = av && m_pronto;
        inv_cond = 0;
        if (!pau) begin
          if (m_timer + 1 >= p) begin
            m_timer = 0;
            m_passo = 1;
            le = (m_x + cmin * ESP) % 2048;
            re = (m_x + cmax * ESP + LARG) % 2048;
            if ((m_dir == 1 && (re + PX) % 2048 > 640) || (m_dir == 0 && le < PX)) begin
              m_y = (m_y + PY) % 1024;
              m_dir = 1 - m_dir;
              be = (m_y + rmax * ESP + LARG) % 2048;
              if (be >= YL) inv_cond = 1;
            end else begin
              m_x = (m_dir == 1) ? (m_x + PX) % 1024 : (m_x + 1024 - PX) % 1024;
            end
          end else begin
            m_timer++;
          end
        end
        if (kill && aidx < N) m_alive[aidx] = 0;
        if (conta() == 0) begin
          m_st = 2; m_limpa = 1; m_pronto = 0;
        end else if (inv_cond) begin
          m_st = 3; m_inv = 1; m_pronto = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vivos"},   32'(vivos),   32'(mascara()));
    chk({tag, ".n_vivos"}, 32'(n_vivos), 32'(conta()));
    chk({tag, ".x_form"},  32'(x_form),  32'(m_x));
    chk({tag, ".y_form"},  32'(y_form),  32'(m_y));
    chk({tag, ".sentido"}, 32'(sentido), 32'(m_dir));
    chk({tag, ".passo"},   32'(passo),   32'(m_passo));
    chk({tag, ".limpa"},   32'(limpa),   32'(m_limpa));
    chk({tag, ".invasao"}, 32'(inv),     32'(m_inv));
    chk({tag, ".pronto"},  32'(bus.abate_pronto), 32'(m_pronto));
  endtask

  task automatic ciclo();
    @(posedge clk);
    model_step();
    #1;
    if (passo === 1'b1) passos++;
    check_all("cyc");
  endtask

  task automatic wait_passo(input int maxc, output int n);
    n = 0;
    do begin
      ciclo();
      n++;
    end while (passo !== 1'b1 && n < maxc);
    chk("passo_timeout", 32'(passo), 32'd1);
  endtask

  task automatic do_kill(input int idx);
    int n = 0;
    av = 1'b1;
    aidx = 3'(idx);
    while (bus.abate_pronto !== 1'b1 && n < 20) begin
      ciclo();
      n++;
    end
    chk("kill_ack", 32'(bus.abate_pronto), 32'd1);
    ciclo();
    av = 1'b0;
  endtask

  task automatic pulse_ini();
    ini = 1'b1;
    ciclo();
    ini = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, hx, hy;
    model_reset();
    ciclo();
    ciclo();
    chk("reset.x", 32'(x_form), 32'd20);
    chk("reset.y", 32'(y_form), 32'd40);
    chk("reset.vivos", 32'(vivos), 32'd0);
    chk("reset.sentido", 32'(sentido), 32'd1);
    rst = 1'b0;

    // Wave start: first step 10 cycles after load
    pulse_ini();
    chk("load.vivos", 32'(vivos), 32'hFF);
    chk("load.n_vivos", 32'(n_vivos), 32'd8);
    repeat (9) ciclo();
    chk("first.no_passo", 32'(passo), 32'd0);
    ciclo();
    chk("first.passo", 32'(passo), 32'd1);
    chk("first.x", 32'(x_form), 32'd40);

    // Right edge drop
    n = 0;
    while (sentido !== 1'b0 && n < 400) begin ciclo(); n++; end
    chk("drop.sentido", 32'(sentido), 32'd0);
    chk("drop.y", 32'(y_form), 32'd60);
    chk("drop.x", 32'(x_form), 32'd480);
    wait_passo(20, n);
    chk("after_drop.x", 32'(x_form), 32'd460);

    // Kills emptying column 3, speed-up, repeated kill
    do_kill(3);
    do_kill(7);
    chk("kill.n_vivos", 32'(n_vivos), 32'd6);
    wait_passo(20, n);
    wait_passo(20, n);
    chk("period_6", 32'(n), 32'd8);
    do_kill(3);
    chk("rekill.n_vivos", 32'(n_vivos), 32'd6);

    // Pause mid-period with a kill inside
    wait_passo(20, n);
    repeat (3) ciclo();
    pau = 1'b1;
    p0 = passos;
    repeat (20) ciclo();
    do_kill(0);
    repeat (28) ciclo();
    chk("pause.passos", 32'(passos - p0), 32'd0);
    chk("pause.kill", 32'(vivos[0]), 32'd0);
    pau = 1'b0;
    wait_passo(20, n);
    chk("pause.resume", 32'(n), 32'd4);

    // Randomized kills and pauses
    for (int i = 0; i < 300; i++) begin
      pau  = ($urandom % 8) == 0;
      av   = ($urandom % 6) == 0;
      aidx = 3'($urandom_range(0, 7));
      ciclo();
    end
    av = 1'b0;
    pau = 1'b0;

    // Clear the whole wave
    pulse_ini();
    for (int k = 0; k < N; k++) do_kill(k);
    chk("clear.limpa", 32'(limpa), 32'd1);
    chk("clear.pronto", 32'(bus.abate_pronto), 32'd0);
    p0 = passos;
    repeat (30) ciclo();
    chk("clear.no_passo", 32'(passos - p0), 32'd0);

    // Invasion
    pulse_ini();
    n = 0;
    while (inv !== 1'b1 && n < 3000) begin ciclo(); n++; end
    chk("inv.flag", 32'(inv), 32'd1);
    chk("inv.y", 32'(y_form), 32'd140);
    hx = 32'(x_form);
    hy = 32'(y_form);
    p0 = passos;
    repeat (30) ciclo();
    chk("inv.frozen_x", 32'(x_form), 32'(hx));
    chk("inv.frozen_y", 32'(y_form), 32'(hy));
    chk("inv.no_passo", 32'(passos - p0), 32'd0);

    // Asynchronous reset during a kill transfer
    pulse_ini();
    repeat (3) ciclo();
    av = 1'b1;
    aidx = 3'd5;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.n_vivos", 32'(n_vivos), 32'd0);
    ciclo();
    rst = 1'b0;
    av = 1'b0;
    ciclo();
    chk("post_rst.vivos", 32'(vivos), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/controle_formacao.md
# controle_formacao

Scheduler for the enemy formation. Holds the alive mask for a COLS×ROWS grid and owns the shared formation origin. Issues paced march steps (right/left, then drop at the screen edges) and shortens the step period as enemies are destroyed. Accepts kill requests from collision logic over a valid/ready handshake, and reports wave-cleared and invasion to the game-state logic.

## Interface
Parameters:
- COLS, 8, grid columns
- ROWS, 4, grid rows
- ESPACO, 40, pixel pitch between enemy cells (x and y)
- LARGURA, 30, enemy sprite width/height in pixels
- PASSO_X, 20, horizontal step in pixels
- PASSO_Y, 20, drop step in pixels
- X0, 20, formation origin x at wave start
- Y0, 40, formation origin y at wave start
- Y_LIMITE, 420, invasion line (pixel y)
- PERIODO_BASE, 25000000, step period in cycles with the full grid alive
- PERIODO_MIN, 2500000, step period floor
- DECREMENTO, 700000, period reduction per destroyed enemy

Ports:
- CLOCK_50  in  1  system clock
- resetInimigo  in  1  reset, asynchronous, active-high
- pausa  in  1  freezes the step timer; kills still accepted
- iniciar_onda  in  1  one-cycle pulse: load a new wave
- abate_valido  in  1  kill request valid
- abate_idx  in  IW=$clog2(COLS*ROWS)  index of the enemy to kill: row*COLS+col
- abate_pronto  out  1  kill request ready
- vivos  out  COLS*ROWS  alive mask, bit idx = enemy idx
- n_vivos  out  IW+1  population count of vivos
- x_form  out  10  formation origin x (cell col at x_form+col*ESPACO)
- y_form  out  10  formation origin y
- sentido  out  1  1 = moving right, 0 = moving left
- passo  out  1  one-cycle pulse on every position change
- onda_limpa  out  1  level: all enemies destroyed
- invasao  out  1  level: formation reached Y_LIMITE

## Operation
- States: OCIOSO, MARCHA, LIMPA, INVADIU.
- Reset values: state OCIOSO; vivos=0; n_vivos=0; x_form=X0; y_form=Y0; sentido=1; passo=0; abate_pronto=0; onda_limpa=0; invasao=0; timer=0.
- iniciar_onda, from any state, has priority over everything else. Next edge: vivos all ones, n_vivos=COLS*ROWS, x_form=X0, y_form=Y0, sentido=1, timer=0, flags cleared, state MARCHA.
- Period P = max(PERIODO_MIN, PERIODO_BASE − (COLS*ROWS − n_vivos)*DECREMENTO). Compute it in 32-bit unsigned and saturate. There must be no underflow.
- Timer behaviour in MARCHA with pausa=0:
  - Timer increments each cycle.
  - When timer ≥ P−1: timer←0 and a step executes.
  - With pausa=1 the timer holds its value.
- Bounds come from the current registered vivos: cmin/cmax = lowest/highest column with any alive bit, rmax = highest alive row.
  - Left edge L = x_form + cmin*ESPACO.
  - Right edge R = x_form + cmax*ESPACO + LARGURA.
  - Bottom B = y_form + rmax*ESPACO + LARGURA.
  - All edge arithmetic is 11-bit unsigned.
- Step rule:
  - sentido=1 and R+PASSO_X > 640: drop. y_form += PASSO_Y, sentido flips, x_form unchanged.
  - sentido=0 and L < PASSO_X: drop, same as above.
  - Otherwise x_form ±= PASSO_X.
  - passo=1 on the cycle the new x_form/y_form become visible.
- Invasion: after any drop, if the new B ≥ Y_LIMITE, go to INVADIU with invasao=1. Position is frozen there.
- Kill handshake:
  - abate_pronto=1 only in MARCHA.
  - A transfer occurs on a cycle with abate_valido & abate_pronto.
  - On the next edge, vivos[abate_idx] clears. If the bit was set, n_vivos decrements.
  - Killing a dead or out-of-range idx (≥COLS*ROWS) is a no-op that is still acknowledged.
- Kill and step on the same cycle: the step uses the pre-kill mask; the kill applies on the same edge.
- When n_vivos reaches 0, go to LIMPA: onda_limpa=1, no further steps, abate_pronto=0.
- LIMPA and INVADIU hold until iniciar_onda or reset.
- resetInimigo mid-step or mid-kill returns all registers immediately to their reset values. A pending kill is dropped.

## Timing
- All outputs are registered.
- Kill takes effect one edge after the transfer. n_vivos updates on the same edge as vivos.
- The new P applies to the following period. The running count is not restarted.
- First step occurs PERIODO_BASE cycles after the edge that loads the wave (pausa=0).
- onda_limpa and invasao assert on the edge after their causing event.

## Structure
- Package pacote_inimigos holds:
  - LARGURA_TELA=640, ALTURA_TELA=480
  - state enum {OCIOSO, MARCHA, LIMPA, INVADIU}
  - default enemy geometry constants
- Sub-module localizador_bordas is purely combinational: mask → cmin, cmax, rmax, plus an any-alive flag. It is instantiated once.

## Test plan
Use COLS=4, ROWS=2, PERIODO_BASE=10, PERIODO_MIN=4, DECREMENTO=1, X0=20, Y0=40, Y_LIMITE=200.
- Wave start and march:
  - Stimulus: pulse iniciar_onda.
  - Response: vivos=8'hFF. passo at cycle 10 with x_form=40, and every 10 cycles after that. While passo is low, x_form does not change.
- Right edge:
  - Stimulus: march until R+20 > 640.
  - Response: next step keeps x_form, sets y_form=60 and sentido=0. The following step gives x_form −20.
- Kill and speed-up:
  - Stimulus: kill idx 3, then idx 7 (column 3 empty).
  - Response: n_vivos=6, period shrinks to 8. The right edge is now computed from cmax=2, so the drop happens 40 px later.
  - Stimulus: repeat kill idx 3.
  - Response: acknowledged, n_vivos stays 6.
- Pause:
  - Stimulus: pausa held 50 cycles mid-period.
  - Response: no passo pulses. Timer resumes from its held value. A kill during the pause still clears its bit.
- Clear and invasion:
  - Stimulus: kill all 8 enemies.
  - Response: onda_limpa=1, abate_pronto=0, no passo.
  - Stimulus: a separate wave left to march until B ≥ 200.
  - Response: invasao=1 and position frozen.
- Reset:
  - Stimulus: assert resetInimigo asynchronously in the middle of a kill transfer.
  - Response: outputs go to reset values immediately, without waiting for a clock edge.
